// File: rtl/ps2_port_rx_if.sv
// ps2_port_rx_if: event bus from the PS/2 receiver to the keyboard-matrix or
// mouse logic. The receiver drives it through the master modport and the
// consumer reads it through the slave modport.
interface ps2_port_rx_if;
  logic       kb_interrupt;  // one-clk pulse: new event valid
  logic [7:0] scancode;      // received byte without prefixes
  logic       released;      // 1 = break code (F0 seen)
  logic       extended;      // 1 = E0 prefix seen

  modport master (output kb_interrupt, scancode, released, extended);
  modport slave  (input  kb_interrupt, scancode, released, extended);
endinterface

// File: rtl/ps2_port_rx.sv
// ps2_port_rx: PS/2 device-to-host receiver.
// The PS/2 pins are synchronised, and the clock pin is deglitched. Each
// falling edge of the filtered clock samples one bit of an 11-bit frame. In
// keyboard mode, the E0 and F0 prefixes are folded into the extended and
// released flags. In mouse mode, every byte is passed through raw.
// Optional build macro: PS2_PARITY_CHECK_EN. When it is defined, frames with
// even parity over data+parity are discarded. When it is not defined, the
// parity bit is ignored.
module ps2_port_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable_rcv,
  input  logic           kb_or_mouse,
  input  logic           ps2clk_ext,
  input  logic           ps2data_ext,
  ps2_port_rx_if.master  evt
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_CHECK = 1'b1;
`else
  localparam bit PARITY_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  // Input conditioning
  logic [1:0]     clk_sync_q, data_sync_q;
  logic           clk_s, data_s;
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           fall;

  // Frame FSM
  state_e         state_q, state_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           timeout_hit;

  // Prefix flags and event outputs
  logic           ext_flag_q, ext_flag_d;
  logic           rel_flag_q, rel_flag_d;
  logic           kb_int_q, kb_int_d;
  logic [7:0]     scancode_q, scancode_d;
  logic           released_q, released_d;
  logic           extended_q, extended_d;
  logic           frame_done, frame_valid, frame_bad, parity_ok, emit;
  logic           is_e0, is_f0;

  // Two-flop synchronisers on both pins; the idle level of the bus is high
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would make the 2-flop chain collapse.
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2clk_ext};
      data_sync_q <= {data_sync_q[0], ps2data_ext};
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // Glitch filter: flip the level only after FILTER_LEN consecutive differing samples
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch
    // can be inferred if a path misses an assignment.
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end
  end

  assign fall = filt_q & ~filt_d;

  // Filter register
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // FSM state register, bit datapath and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
    end
  end

  assign timeout_hit = (state_q != S_IDLE) && !fall &&
                       (tmo_q == TCW'(TIMEOUT_CYCLES - 1));

  // Next-state logic: one state step per sampled edge, with abort on disable or timeout
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_d     = (state_q == S_IDLE || fall) ? '0 : tmo_q + TCW'(1);

    if (!enable_rcv) begin
      state_d   = S_IDLE;
      bit_idx_d = '0;
      tmo_d     = '0;
    end else if (fall) begin
      unique case (state_q)
        S_IDLE: begin
          if (!data_s) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end
        S_DATA: begin
          shift_d = {data_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        S_PARITY: begin
          parity_d = data_s;
          state_d  = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d   = S_IDLE;
      bit_idx_d = '0;
    end
  end

  // Output logic: classify the finished frame and compute the flags and the event
  always_comb begin
    frame_done  = enable_rcv && fall && (state_q == S_STOP);
    parity_ok   = ^{shift_q, parity_q};
    frame_valid = frame_done && data_s && (parity_ok || !PARITY_CHECK);
    frame_bad   = frame_done && !frame_valid;
    is_e0       = (shift_q == 8'hE0);
    is_f0       = (shift_q == 8'hF0);
    emit        = frame_valid && (kb_or_mouse || !(is_e0 || is_f0));

    ext_flag_d = ext_flag_q;
    rel_flag_d = rel_flag_q;
    if (frame_bad) begin
      ext_flag_d = 1'b0;
      rel_flag_d = 1'b0;
    end else if (frame_valid && !kb_or_mouse) begin
      if (is_e0) begin
        ext_flag_d = 1'b1;
      end else if (is_f0) begin
        rel_flag_d = 1'b1;
      end else begin
        ext_flag_d = 1'b0;
        rel_flag_d = 1'b0;
      end
    end

    kb_int_d   = emit;
    scancode_d = emit ? shift_q : scancode_q;
    released_d = emit ? (!kb_or_mouse && rel_flag_q) : released_q;
    extended_d = emit ? (!kb_or_mouse && ext_flag_q) : extended_q;
  end

  // Event and prefix-flag registers; outputs hold until the next event
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_flag_q <= 1'b0;
      rel_flag_q <= 1'b0;
      kb_int_q   <= 1'b0;
      scancode_q <= 8'h00;
      released_q <= 1'b0;
      extended_q <= 1'b0;
    end else begin
      ext_flag_q <= ext_flag_d;
      rel_flag_q <= rel_flag_d;
      kb_int_q   <= kb_int_d;
      scancode_q <= scancode_d;
      released_q <= released_d;
      extended_q <= extended_d;
    end
  end

  assign evt.kb_interrupt = kb_int_q;
  assign evt.scancode     = scancode_q;
  assign evt.released     = released_q;
  assign evt.extended     = extended_q;

endmodule

// File: tb/tb_ps2_port_rx.sv
// tb_ps2_port_rx: directed self-checking bench for ps2_port_rx (default build,
// parity bit ignored). Frames are bit-banged on the PS/2 pins, and interrupt
// pulses are counted one clk at a time.
module tb_ps2_port_rx;

  localparam int HALF = 40;    // PS/2 half bit period in clk cycles
  localparam int TMO  = 2000;  // shortened timeout for simulation

  logic clk = 1'b0;
  logic rst, enable_rcv, kb_or_mouse, ps2clk_ext, ps2data_ext;
  int   total = 0;
  int   bad   = 0;
  int   pulses = 0;
  int   p0;

  ps2_port_rx_if evt_if ();

  ps2_port_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_rcv  (enable_rcv),
    .kb_or_mouse (kb_or_mouse),
    .ps2clk_ext  (ps2clk_ext),
    .ps2data_ext (ps2data_ext),
    .evt         (evt_if)
  );

  always #5 clk = ~clk;

  // Count interrupt-high cycles; a stretched pulse shows up as an extra count
  always @(negedge clk) begin
    if (evt_if.kb_interrupt === 1'b1) pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par,
                                             input bit stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {stop, par, b, 1'b0};
  endfunction

  // Drive frame bits lo..hi: data is set while the clock is high, then the clock pulses low
  task automatic send_range(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ps2data_ext = f[i];
      tick(HALF);
      ps2clk_ext = 1'b0;
      tick(HALF);
      ps2clk_ext = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_range(make_frame(b, 1'b0, 1'b1), 0, 10);
    tick(HALF);
    ps2data_ext = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable_rcv = 1'b1; kb_or_mouse = 1'b0;
    ps2clk_ext = 1'b1; ps2data_ext = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(2);

    // Reset state
    check("rst_int", evt_if.kb_interrupt, 0);
    check("rst_code", evt_if.scancode, 8'h00);
    check("rst_rel", evt_if.released, 0);
    check("rst_ext", evt_if.extended, 0);
    check("rst_pulses", pulses, 0);

    // Plain make code
    p0 = pulses;
    send_frame(8'h1C);
    check("make_pulse", pulses - p0, 1);
    check("make_code", evt_if.scancode, 8'h1C);
    check("make_rel", evt_if.released, 0);
    check("make_ext", evt_if.extended, 0);

    // Break: F0 1C, then a plain 1C clears released
    p0 = pulses;
    send_frame(8'hF0);
    check("f0_nopulse", pulses - p0, 0);
    send_frame(8'h1C);
    check("brk_pulse", pulses - p0, 1);
    check("brk_code", evt_if.scancode, 8'h1C);
    check("brk_rel", evt_if.released, 1);
    check("brk_ext", evt_if.extended, 0);
    send_frame(8'h1C);
    check("after_brk_rel", evt_if.released, 0);

    // Extended break: E0 F0 75
    p0 = pulses;
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    check("ebrk_pulse", pulses - p0, 1);
    check("ebrk_code", evt_if.scancode, 8'h75);
    check("ebrk_rel", evt_if.released, 1);
    check("ebrk_ext", evt_if.extended, 1);

    // Mouse mode: raw bytes, prefixes not decoded
    kb_or_mouse = 1'b1;
    p0 = pulses;
    send_frame(8'hF0);
    check("m1_pulse", pulses - p0, 1);
    check("m1_code", evt_if.scancode, 8'hF0);
    check("m1_rel", evt_if.released, 0);
    check("m1_ext", evt_if.extended, 0);
    send_frame(8'h08);
    check("m2_pulse", pulses - p0, 2);
    check("m2_code", evt_if.scancode, 8'h08);
    check("m2_rel", evt_if.released, 0);
    kb_or_mouse = 1'b0;
    send_frame(8'h1C);
    check("m_noflag_rel", evt_if.released, 0);

    // Wrong parity bit is ignored in the default build
    p0 = pulses;
    send_range(make_frame(8'h3A, 1'b1, 1'b1), 0, 10);
    tick(HALF);
    check("badpar_pulse", pulses - p0, 1);
    check("badpar_code", evt_if.scancode, 8'h3A);

    // Bad stop bit: discarded, prefix flags cleared
    p0 = pulses;
    send_frame(8'hF0);
    send_range(make_frame(8'h1C, 1'b0, 1'b0), 0, 10);
    tick(HALF);
    ps2data_ext = 1'b1;
    check("badstop_nopulse", pulses - p0, 0);
    check("badstop_code", evt_if.scancode, 8'h3A);
    send_frame(8'h1C);
    check("badstop_next_pulse", pulses - p0, 1);
    check("badstop_next_rel", evt_if.released, 0);

    // Timeout: truncated frame is dropped, prefix flag survives
    p0 = pulses;
    send_frame(8'hE0);
    send_range(make_frame(8'h55, 1'b0, 1'b1), 0, 3);
    ps2data_ext = 1'b1;
    tick(TMO + 100);
    send_frame(8'h2A);
    check("tmo_pulse", pulses - p0, 1);
    check("tmo_code", evt_if.scancode, 8'h2A);
    check("tmo_ext", evt_if.extended, 1);
    check("tmo_rel", evt_if.released, 0);

    // Short low glitches with data low must not start a frame
    p0 = pulses;
    ps2data_ext = 1'b0;
    for (int g = 0; g < 5; g++) begin
      ps2clk_ext = 1'b0;
      tick(3);
      ps2clk_ext = 1'b1;
      tick(20);
    end
    ps2data_ext = 1'b1;
    tick(HALF);
    check("glitch_nopulse", pulses - p0, 0);
    send_frame(8'h1C);
    check("glitch_next_pulse", pulses - p0, 1);
    check("glitch_next_code", evt_if.scancode, 8'h1C);
    check("glitch_next_ext", evt_if.extended, 0);

    // Enable dropped mid-frame: that frame yields nothing
    p0 = pulses;
    send_range(make_frame(8'h55, 1'b0, 1'b1), 0, 4);
    enable_rcv = 1'b0;
    send_range(make_frame(8'h55, 1'b0, 1'b1), 5, 10);
    ps2data_ext = 1'b1;
    tick(HALF);
    enable_rcv = 1'b1;
    tick(HALF);
    check("en_nopulse", pulses - p0, 0);
    check("en_code_hold", evt_if.scancode, 8'h1C);
    send_frame(8'h2A);
    check("en_next_pulse", pulses - p0, 1);
    check("en_next_code", evt_if.scancode, 8'h2A);

    // Reset mid-frame: outputs and prefix flags return to reset values
    send_frame(8'hF0);
    send_range(make_frame(8'h66, 1'b0, 1'b1), 0, 4);
    ps2data_ext = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("mrst_int", evt_if.kb_interrupt, 0);
    check("mrst_code", evt_if.scancode, 8'h00);
    check("mrst_rel", evt_if.released, 0);
    p0 = pulses;
    send_frame(8'h2A);
    check("mrst_next_pulse", pulses - p0, 1);
    check("mrst_next_code", evt_if.scancode, 8'h2A);
    check("mrst_next_rel", evt_if.released, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
